spi_flash_cmd_seq: RTL and testbench

Command sequencer that sits above the bit-level SPI shifter (start_trig / dataLength / indata / recvdata / isbusy) and turns single host requests into complete flash transactions.
- Builds opcode/address/data frames, owns flash chip-select, and inserts WREN before program/erase.
- Polls the status register until the write-in-progress (WIP) bit clears, then returns one response per command.
- Sits between the host command bus and the shifter instance inside the SPI flash top level.

---
 rtl/spi_flash_cmd_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_spi_flash_cmd_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_cmd_seq.sv
// SPI flash command sequencer: turns one host request into a full flash
// transaction on top of the bit-level shifter (WREN insertion, CS framing,
// WIP status polling, one response per command).
module spi_flash_cmd_seq #(
  parameter int unsigned POLL_MAX = 4096,
  parameter int unsigned CS_GAP   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [23:0]  cmd_addr,
  input  logic [31:0]  cmd_wdata,
  output logic         rsp_valid,
  output logic [31:0]  rsp_data,
  output logic         rsp_err,
  output logic         flash_cs_n,
  output logic         sh_start,
  output logic [7:0]   sh_len,
  output logic [127:0] sh_data,
  input  logic [127:0] sh_rdata,
  input  logic         sh_busy
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam int unsigned GW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_CHECK, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    F_WREN, F_OP, F_RDSR
  } frame_t;

  typedef enum logic [2:0] {
    OP_READ_ID     = 3'd0,
    OP_READ        = 3'd1,
    OP_PROGRAM     = 3'd2,
    OP_ERASE       = 3'd3,
    OP_READ_STATUS = 3'd4
  } op_t;

  state_t         state;
  frame_t         frame_q;
  op_t            op_q;
  logic [23:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [PW-1:0]  poll_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [7:0]     status_q;
  logic [31:0]    res_q;
  logic           err_q;

  // Only the low word of the receive register carries any response field.
  logic unused_rdata;
  assign unused_rdata = ^sh_rdata[127:32];

  function automatic logic [7:0] frame_len(input frame_t f, input op_t op);
    logic [7:0] l;
    l = 8'd0;
    case (f)
      F_WREN: l = 8'd8;
      F_RDSR: l = 8'd16;
      default: begin
        case (op)
          OP_READ_ID: l = 8'd32;
          OP_READ:    l = 8'd64;
          OP_PROGRAM: l = 8'd64;
          OP_ERASE:   l = 8'd32;
          default:    l = 8'd16;
        endcase
      end
    endcase
    return l;
  endfunction

  function automatic logic [127:0] frame_data(input frame_t f, input op_t op,
                                               input logic [23:0] a,
                                               input logic [31:0] w);
    logic [127:0] d;
    d = '0;
    case (f)
      F_WREN: d = {120'h0, 8'h06};
      F_RDSR: d = {112'h0, 8'h05, 8'h00};
      default: begin
        case (op)
          OP_READ_ID: d = {96'h0, 8'h9F, 24'h0};
          OP_READ:    d = {64'h0, 8'h03, a, 32'h0};
          OP_PROGRAM: d = {64'h0, 8'h02, a, w};
          OP_ERASE:   d = {96'h0, 8'h20, a};
          default:    d = {112'h0, 8'h05, 8'h00};
        endcase
      end
    endcase
    return d;
  endfunction

  // Transaction FSM; every output is a register updated here.
  // Outputs lag their state by one cycle: LOAD drives the frame and CS low
  // (visible in START, giving one cycle of CS setup), START raises sh_start
  // (visible in the first WAIT_BUSY cycle), RESP raises rsp_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      frame_q    <= F_WREN;
      op_q       <= OP_READ_ID;
      addr_q     <= '0;
      wdata_q    <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
      status_q   <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      flash_cs_n <= 1'b1;
      sh_start   <= 1'b0;
      sh_len     <= '0;
      sh_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= op_t'(cmd_op);
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            poll_cnt  <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            if (cmd_op > 3'd4) begin
              err_q <= 1'b1;
              state <= S_RESP;
            end else begin
              if (cmd_op == 3'd2 || cmd_op == 3'd3)
                frame_q <= F_WREN;
              else if (cmd_op == 3'd4)
                frame_q <= F_RDSR;
              else
                frame_q <= F_OP;
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          sh_len     <= frame_len(frame_q, op_q);
          sh_data    <= frame_data(frame_q, op_q, addr_q, wdata_q);
          flash_cs_n <= 1'b0;
          state      <= S_START;
        end

        S_START: begin
          sh_start <= 1'b1;
          state    <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY: begin
          sh_start <= 1'b0;
          if (sh_busy)
            state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (!sh_busy) begin
            flash_cs_n <= 1'b1;
            gap_cnt    <= '0;
            state      <= S_GAP;
            if (frame_q == F_RDSR) begin
              status_q <= sh_rdata[7:0];
              if (poll_cnt != PW'(POLL_MAX))
                poll_cnt <= poll_cnt + 1'b1;
            end else if (frame_q == F_OP) begin
              if (op_q == OP_READ_ID)
                res_q <= {8'h00, sh_rdata[23:0]};
              else if (op_q == OP_READ)
                res_q <= sh_rdata[31:0];
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GW'(CS_GAP - 1))
            state <= S_CHECK;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end

        S_CHECK: begin
          if (op_q == OP_PROGRAM || op_q == OP_ERASE) begin
            case (frame_q)
              F_WREN: begin
                frame_q <= F_OP;
                state   <= S_LOAD;
              end
              F_OP: begin
                frame_q <= F_RDSR;
                state   <= S_LOAD;
              end
              default: begin
                if (!status_q[0]) begin
                  res_q <= {24'h0, status_q};
                  state <= S_RESP;
                end else if (poll_cnt >= PW'(POLL_MAX)) begin
                  res_q <= {24'h0, status_q};
                  err_q <= 1'b1;
                  state <= S_RESP;
                end else begin
                  state <= S_LOAD;
                end
              end
            endcase
          end else if (op_q == OP_READ_STATUS) begin
            res_q <= {24'h0, status_q};
            state <= S_RESP;
          end else begin
            state <= S_RESP;
          end
        end

        S_RESP: begin
          rsp_valid <= 1'b1;
          rsp_data  <= res_q;
          rsp_err   <= err_q;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_seq.sv
// Directed bench for spi_flash_cmd_seq with a behavioural shifter/flash
// model, a spec-level expectation model and one negedge compare process.
module tb_spi_flash_cmd_seq;

  localparam int PM  = 8;
  localparam int GAP = 4;
  localparam logic [31:0] ID_WORD = 32'hAAEF4018;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [23:0]  cmd_addr;
  logic [31:0]  cmd_wdata;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_data;
  logic         flash_cs_n, sh_start, sh_busy;
  logic [7:0]   sh_len;
  logic [127:0] sh_data, sh_rdata;

  spi_flash_cmd_seq #(.POLL_MAX(PM), .CS_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flash_cs_n(flash_cs_n), .sh_start(sh_start), .sh_len(sh_len),
    .sh_data(sh_data), .sh_rdata(sh_rdata), .sh_busy(sh_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [7:0] len; logic [127:0] data; } frame_s;
  typedef struct { logic [31:0] d; logic e; } rsp_s;

  frame_s       exp_f[$];
  rsp_s         exp_r[$];
  logic [127:0] flog[$];

  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int windows = 0;
  int wip_cfg = 0;
  int wip_left = 0;
  logic [31:0] last_d;
  logic        last_e;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", nm, what);
  endtask

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return (a == 24'h012345) ? 32'hDEADBEEF : {8'h11, a};
  endfunction

  // Spec-level expectation: frame list and response per command.
  task automatic push_expect(input logic [2:0] op, input logic [23:0] a,
                             input logic [31:0] w, input int nwip);
    int polls;
    case (op)
      3'd0: begin
        exp_f.push_back('{len: 8'd32, data: {96'h0, 8'h9F, 24'h0}});
        exp_r.push_back('{d: ID_WORD & 32'h00FFFFFF, e: 1'b0});
      end
      3'd1: begin
        exp_f.push_back('{len: 8'd64, data: {64'h0, 8'h03, a, 32'h0}});
        exp_r.push_back('{d: mem_word(a), e: 1'b0});
      end
      3'd2, 3'd3: begin
        exp_f.push_back('{len: 8'd8, data: {120'h0, 8'h06}});
        if (op == 3'd2)
          exp_f.push_back('{len: 8'd64, data: {64'h0, 8'h02, a, w}});
        else
          exp_f.push_back('{len: 8'd32, data: {96'h0, 8'h20, a}});
        polls = (nwip < PM) ? nwip + 1 : PM;
        for (int i = 0; i < polls; i++)
          exp_f.push_back('{len: 8'd16, data: {112'h0, 16'h0500}});
        if (nwip < PM) exp_r.push_back('{d: 32'h0, e: 1'b0});
        else           exp_r.push_back('{d: 32'h1, e: 1'b1});
      end
      3'd4: begin
        exp_f.push_back('{len: 8'd16, data: {112'h0, 16'h0500}});
        exp_r.push_back('{d: {31'h0, nwip > 0}, e: 1'b0});
      end
      default: exp_r.push_back('{d: 32'h0, e: 1'b1});
    endcase
  endtask

  // Shifter + flash model: answers each started frame after a bit-time delay.
  initial begin
    logic [7:0]   fl;
    logic [127:0] fd, resp;
    logic [7:0]   op8;
    sh_busy  = 1'b0;
    sh_rdata = '0;
    forever begin
      @(negedge clk);
      if (sh_start && !rst) begin
        fl   = sh_len;
        fd   = sh_data;
        op8  = fd[int'(fl) - 1 -: 8];
        resp = '0;
        case (op8)
          8'h9F: resp[31:0] = ID_WORD;
          8'h03: resp[31:0] = mem_word(fd[55:32]);
          8'h05: begin
            resp[15:0] = {8'h5A, 7'h0, wip_left > 0};
            if (wip_left > 0) wip_left--;
          end
          8'h02, 8'h20: wip_left = wip_cfg;
          default: ;
        endcase
        @(negedge clk);
        sh_busy = 1'b1;
        for (int i = 0; i < int'(fl) / 8 + 1; i++) begin
          @(negedge clk);
          if (rst) break;
        end
        sh_rdata = resp;
        sh_busy  = 1'b0;
      end
    end
  end

  // Compare process: frames, responses, CS windows and gaps.
  initial begin
    logic         prev_cs;
    int           high_cnt;
    logic [127:0] win_data;
    logic [7:0]   win_len;
    frame_s       ef;
    rsp_s         er;
    prev_cs  = 1'b1;
    high_cnt = 0;
    win_data = '0;
    win_len  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sh_start) begin
          frames_seen++;
          flog.push_back(sh_data);
          chk("start_cs_low", {127'h0, flash_cs_n}, 128'h0);
          if (exp_f.size() == 0) begin
            fail_evt("unexpected_start", "got sh_start=1 expected no frame");
          end else begin
            ef = exp_f.pop_front();
            chk("frame_len", {120'h0, sh_len}, {120'h0, ef.len});
            chk("frame_data", sh_data, ef.data);
          end
        end
        if (rsp_valid) begin
          last_d = rsp_data;
          last_e = rsp_err;
          if (exp_r.size() == 0) begin
            fail_evt("unexpected_rsp", "got rsp_valid=1 expected 0");
          end else begin
            er = exp_r.pop_front();
            chk("rsp_data", {96'h0, rsp_data}, {96'h0, er.d});
            chk("rsp_err", {127'h0, rsp_err}, {127'h0, er.e});
          end
        end
        if (!flash_cs_n) begin
          if (prev_cs) begin
            windows++;
            if (windows > 1)
              chk("cs_gap_min", {127'h0, high_cnt >= GAP}, 128'h1);
            win_data = sh_data;
            win_len  = sh_len;
          end else begin
            chk("frame_stable", sh_data, win_data);
            chk("len_stable", {120'h0, sh_len}, {120'h0, win_len});
          end
          high_cnt = 0;
        end else begin
          high_cnt++;
        end
        prev_cs = flash_cs_n;
      end
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [23:0] a,
                        input logic [31:0] w, input int nwip,
                        input bit wait_rsp, output int lat);
    int n;
    bit got;
    if (op == 3'd2 || op == 3'd3) wip_cfg = nwip;
    if (op == 3'd4) wip_left = nwip;
    push_expect(op, a, w, nwip);
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_evt("ready_timeout", "got cmd_ready=0 expected 1");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = w;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
      if (!wait_rsp) got = 1'b1;
      else if (rsp_valid) got = 1'b1;
    end
    if (!got) fail_evt("rsp_timeout", "got no rsp_valid expected one");
    if (wait_rsp) @(negedge clk);
  endtask

  initial begin
    int lat, f0, w0, n;
    logic [127:0] fv;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {127'h0, cmd_ready}, 128'h0);
    chk("rst_rsp_valid", {127'h0, rsp_valid}, 128'h0);
    chk("rst_rsp_data", {96'h0, rsp_data}, 128'h0);
    chk("rst_rsp_err", {127'h0, rsp_err}, 128'h0);
    chk("rst_cs_n", {127'h0, flash_cs_n}, 128'h1);
    chk("rst_sh_start", {127'h0, sh_start}, 128'h0);
    chk("rst_sh_len", {120'h0, sh_len}, 128'h0);
    chk("rst_sh_data", sh_data, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {127'h0, cmd_ready}, 128'h1);

    // READ_ID
    w0 = windows;
    do_cmd(3'd0, 24'h0, 32'h0, 0, 1'b1, lat);
    fv = flog[flog.size() - 1];
    chk("readid_opcode", {120'h0, fv[31:24]}, 128'h9F);
    chk("readid_rsp_lit", {96'h0, last_d}, 128'h00EF4018);
    chk("readid_one_window", windows - w0, 1);

    // READ
    do_cmd(3'd1, 24'h012345, 32'h0, 0, 1'b1, lat);
    chk("read_frame_lit", flog[flog.size() - 1], 128'h03012345_00000000);
    chk("read_rsp_lit", {96'h0, last_d}, 128'hDEADBEEF);

    // PROGRAM with WIP for 3 polls
    f0 = frames_seen;
    do_cmd(3'd2, 24'h000100, 32'hA5A5A5A5, 3, 1'b1, lat);
    chk("prog_frame_count", frames_seen - f0, 6);
    chk("prog_frame_lit", flog[f0 + 1], 128'h02000100_A5A5A5A5);
    chk("prog_rsp_lit", {95'h0, last_e, last_d}, 128'h0);

    // ERASE with WIP stuck
    f0 = frames_seen;
    do_cmd(3'd3, 24'h003000, 32'h0, 100000, 1'b1, lat);
    chk("erase_frame_count", frames_seen - f0, 10);
    chk("erase_err_lit", {127'h0, last_e}, 128'h1);
    chk("erase_wip_lit", {127'h0, last_d[0]}, 128'h1);
    chk("erase_ready_back", {127'h0, cmd_ready}, 128'h1);

    // Illegal op
    f0 = frames_seen;
    w0 = windows;
    do_cmd(3'd6, 24'h0, 32'h0, 0, 1'b1, lat);
    chk("illegal_latency", lat, 2);
    chk("illegal_no_frame", frames_seen - f0, 0);
    chk("illegal_no_cs", windows - w0, 0);
    chk("illegal_err_lit", {127'h0, last_e}, 128'h1);

    // READ_STATUS while WIP set
    do_cmd(3'd4, 24'h0, 32'h0, 2, 1'b1, lat);
    chk("rdsr_busy_lit", {96'h0, last_d}, 128'h1);

    // Reset during PROGRAM data frame
    f0 = frames_seen;
    do_cmd(3'd2, 24'h000200, 32'h12345678, 2, 1'b0, lat);
    n = 0;
    while (frames_seen < f0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frames_seen < f0 + 2) fail_evt("data_frame_timeout", "got no data frame expected one");
    @(negedge clk);
    chk("pre_rst_cs_low", {127'h0, flash_cs_n}, 128'h0);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_cs_n", {127'h0, flash_cs_n}, 128'h1);
    chk("async_rst_start", {127'h0, sh_start}, 128'h0);
    chk("async_rst_ready", {127'h0, cmd_ready}, 128'h0);
    repeat (3) @(negedge clk);
    exp_f.delete();
    exp_r.delete();
    wip_left = 0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // READ_STATUS after reset, then a plain READ
    do_cmd(3'd4, 24'h0, 32'h0, 0, 1'b1, lat);
    chk("rdsr_after_rst", {95'h0, last_e, last_d}, 128'h0);
    do_cmd(3'd1, 24'h0000FF, 32'h0, 0, 1'b1, lat);
    chk("read2_rsp_lit", {96'h0, last_d}, 128'h110000FF);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
